// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg: shared state encoding and byte-width constants for the sequential add/subtract controller
package addsub_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam int MAX_WORDS = 16;
endpackage

// File: rtl/adder_slice8.sv
// adder_slice8: 8-bit ripple-carry slice built from full adders
module adder_slice8
  import addsub_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);
  logic [BYTE_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[BYTE_W];
endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: byte-serial WORDS x 8-bit add/subtract over one shared adder slice
// Define ADDSUB_SEQ_SUB_EN to enable subtract via op; otherwise every operation is an add.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [BYTE_W*WORDS-1:0] a,
  input  logic [BYTE_W*WORDS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BYTE_W*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int W  = BYTE_W * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r, b_in;
  logic [IW-1:0] idx;
  logic [BYTE_W-1:0] s;
  logic carry, c_in, sc, cmsb, last;
`ifdef ADDSUB_SEQ_SUB_EN
  assign b_in = op ? ~b : b;
  assign c_in = op ? 1'b1 : cin;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_in = b;
  assign c_in = cin;
`endif
  // operand registers shift right so the slice always sees the current byte at the bottom
  adder_slice8 u_slice (
    .a   (a_r[BYTE_W-1:0]),
    .b   (b_r[BYTE_W-1:0]),
    .cin (carry),
    .sum (s),
    .cout(sc)
  );
  assign cmsb = a_r[BYTE_W-1] ^ b_r[BYTE_W-1] ^ s[BYTE_W-1];
  assign last = idx == IW'(WORDS - 1);
  always_comb begin
    state_n   = (state == IDLE && in_valid) ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r   <= a;
        b_r   <= b_in;
        carry <= c_in;
        idx   <= '0;
      end else if (state == RUN) begin
        a_r   <= a_r >> BYTE_W;
        b_r   <= b_r >> BYTE_W;
        carry <= sc;
        idx   <= idx + 1'b1;
        for (int j = 0; j < WORDS; j++)
          if (idx == IW'(j)) sum[j*BYTE_W +: BYTE_W] <= s;
        if (last) begin
          cout <= sc;
          ovf  <= cmsb ^ sc;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: directed self-checking bench for addsub_seq_ctrl (WORDS=4)
module tb_addsub_seq_ctrl;
  localparam int WORDS = 4;
  localparam int W = 8 * WORDS;
  logic clk = 1'b0;
  logic rst, in_valid, op, cin, out_ready;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  addsub_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " rdy after"}, 64'(in_ready), 64'd1);
    check({tag, " vld after"}, 64'(out_valid), 64'd0);
  endtask
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic opv, input logic cv, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int cyc;
    @(negedge clk);
    a = av; b = bv; op = opv; cin = cv; in_valid = 1'b1;
    check({tag, " rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    wait_done(cyc);
    check({tag, " lat"}, 64'(cyc), 64'(WORDS));
    check({tag, " sum"}, 64'(sum), 64'(es));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " ovf"}, 64'(ovf), 64'(eo));
    handshake(tag);
  endtask
  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    check("rst rdy", 64'(in_ready), 64'd1);
    check("rst vld", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst sum", 64'(sum), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("add_cin", 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0);
`ifdef ADDSUB_SEQ_SUB_EN
    run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
`else
    run_op("op_ign", 32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0);
`endif
    // backpressure: result must freeze while out_ready is low
    @(negedge clk);
    a = 32'hC0000000; b = 32'h40000001; op = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    check("bp lat", 64'(cyc), 64'(WORDS));
    for (int i = 0; i < 10; i++) begin
      check("bp vld", 64'(out_valid), 64'd1);
      check("bp rdy", 64'(in_ready), 64'd0);
      check("bp sum", 64'(sum), 64'h00000001);
      check("bp cout", 64'(cout), 64'd1);
      check("bp ovf", 64'(ovf), 64'd0);
      @(posedge clk); #1;
    end
    handshake("bp");
    // operands churn during RUN with in_valid held high
    @(negedge clk);
    a = 32'h01010101; b = 32'h02020202; op = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      check("churn rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
      a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check("churn lat", 64'(cyc), 64'(WORDS));
    check("churn sum", 64'(sum), 64'h03030303);
    check("churn cout", 64'(cout), 64'd0);
    check("churn ovf", 64'(ovf), 64'd0);
    check("churn done rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    handshake("churn");
    // asynchronous reset two cycles into RUN
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; op = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst rdy", 64'(in_ready), 64'd1);
    check("arst vld", 64'(out_valid), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst sum", 64'(sum), 64'd0);
    check("arst cout", 64'(cout), 64'd0);
    check("arst ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
